serial_adder_ctrl: RTL and testbench



---
 rtl/serial_add_pkg.sv | 20 ++
 rtl/serial_adder_ctrl_if.sv | 31 +++
 rtl/serial_adder_ctrl_q1.sv | 19 +
 rtl/serial_adder_ctrl.sv | 99 +++++++++
 tb/tb_serial_adder_ctrl.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_pkg.sv
// ============================================================================
// Module      : serial_add_pkg
// Description : Shared state encoding and default width for the serial adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_add_pkg;

    localparam int SA_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_adder_ctrl_if.sv
// ============================================================================
// Module      : serial_adder_ctrl_if
// Description : Host-side request/result bundle for the serial adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_adder_ctrl_if #(
    parameter int WIDTH = serial_add_pkg::SA_WIDTH_DEF
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a_in, b_in, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a_in, b_in, cin,
        output busy, done, sum, cout
    );
endinterface

`default_nettype wire

// File: rtl/serial_adder_ctrl_q1.sv
// ============================================================================
// Module      : q1
// Description : One-bit full-adder cell shared by the serial adder datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module q1 (
    output logic y0,
    output logic y1,
    input  logic a,
    input  logic b,
    input  logic c
);
    assign y0 = a ^ b ^ c;
    assign y1 = (a & b) | (a & c) | (b & c);
endmodule

`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
// ============================================================================
// Module      : serial_adder_ctrl
// Description : Bit-serial WIDTH-bit adder, LSB first, one q1 cell reused per bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    serial_adder_ctrl_if.slave  bus
);
    localparam int              c_cnt_w = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   a_sh_q;
    logic [WIDTH-1:0]   b_sh_q;
    logic [WIDTH-1:0]   s_sh_q;
    logic               carry_q;
    logic [c_cnt_w-1:0] cnt_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;

    logic               w_y0;
    logic               w_y1;
    logic [WIDTH-1:0]   w_sum_shift;

    q1 u_q1 (
        .y0 (w_y0),
        .y1 (w_y1),
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .c  (carry_q)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at the LSB.
    assign w_sum_shift = WIDTH'({w_y0, s_sh_q} >> 1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (cnt_q == c_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_sh_q  <= bus.a_in;
                        b_sh_q  <= bus.b_in;
                        carry_q <= bus.cin;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    s_sh_q  <= w_sum_shift;
                    carry_q <= w_y1;
                    cnt_q   <= cnt_q + c_cnt_w'(1);
                    if (cnt_q == c_last) begin
                        sum_q  <= w_sum_shift;
                        cout_q <= w_y1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
// ============================================================================
// Module      : tb_serial_adder_ctrl
// Description : Self-checking bench: WIDTH=8 vectors/corners, WIDTH=3 sweep.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_adder_ctrl_if #(.WIDTH(3)) bus3 ();

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
    serial_adder_ctrl #(.WIDTH(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Scoreboards: reference sums queued at acceptance, consumed in the DONE cycle.
    logic [8:0] q8[$];
    logic [3:0] q3[$];
    int         m8_cnt = 0;
    int         m3_cnt = 0;
    logic [8:0] m8_res = '0;
    logic [3:0] m3_res = '0;

    // Protocol model: busy for WIDTH+1 cycles after acceptance, DONE is the last.
    always @(negedge clk) begin
        if (m8_cnt == 1) begin
            if (q8.size() == 0) check("sb8_underflow", 1, 0);
            else m8_res = q8.pop_front();
        end
        check("busy8", bus8.busy, m8_cnt != 0);
        check("done8", bus8.done, m8_cnt == 1);
        check("res8", {bus8.cout, bus8.sum}, m8_res);
        if (rst) begin
            m8_cnt = 0;
            q8.delete();
            m8_res = '0;
        end else if (m8_cnt == 0) begin
            if (bus8.start) begin
                q8.push_back({1'b0, bus8.a_in} + {1'b0, bus8.b_in} + 9'(bus8.cin));
                m8_cnt = 9;
            end
        end else begin
            m8_cnt--;
        end
    end

    always @(negedge clk) begin
        if (m3_cnt == 1) begin
            if (q3.size() == 0) check("sb3_underflow", 1, 0);
            else m3_res = q3.pop_front();
        end
        check("busy3", bus3.busy, m3_cnt != 0);
        check("done3", bus3.done, m3_cnt == 1);
        check("res3", {bus3.cout, bus3.sum}, m3_res);
        if (rst) begin
            m3_cnt = 0;
            q3.delete();
            m3_res = '0;
        end else if (m3_cnt == 0) begin
            if (bus3.start) begin
                q3.push_back({1'b0, bus3.a_in} + {1'b0, bus3.b_in} + 4'(bus3.cin));
                m3_cnt = 4;
            end
        end else begin
            m3_cnt--;
        end
    end

    task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic c);
        int guard = 0;
        @(posedge clk); #1;
        while (m8_cnt != 0 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        bus8.start = 1'b1; bus8.a_in = a; bus8.b_in = b; bus8.cin = c;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        bus8.a_in  = 8'($urandom);
        bus8.b_in  = 8'($urandom);
        bus8.cin   = 1'($urandom);
    endtask

    task automatic go3(input logic [2:0] a, input logic [2:0] b, input logic c);
        int guard = 0;
        @(posedge clk); #1;
        while (m3_cnt != 0 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        bus3.start = 1'b1; bus3.a_in = a; bus3.b_in = b; bus3.cin = c;
        @(posedge clk); #1;
        bus3.start = 1'b0;
        bus3.a_in  = 3'($urandom);
        bus3.b_in  = 3'($urandom);
        bus3.cin   = 1'($urandom);
    endtask

    task automatic wait_done8(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus8.done) seen = 1'b1;
        end
        check({tag, "_timeout"}, 32'(seen), 1);
    endtask

    task automatic wait_done3(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus3.done) seen = 1'b1;
        end
        check({tag, "_timeout"}, 32'(seen), 1);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int t1;
        int t2;
        bit saw_done;
        logic [3:0] ref3;

        tbl[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        tbl[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[4] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
        tbl[5] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
        tbl[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

        bus8.start = 1'b0; bus8.a_in = '0; bus8.b_in = '0; bus8.cin = 1'b0;
        bus3.start = 1'b0; bus3.a_in = '0; bus3.b_in = '0; bus3.cin = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", bus8.busy, 0);
        check("rst_done", bus8.done, 0);
        check("rst_sum",  bus8.sum,  0);
        check("rst_cout", bus8.cout, 0);

        // Cycle-exact latency: busy in cycles 1..9, done only in cycle 9.
        go8(8'h35, 8'h4A, 1'b0);
        for (int j = 1; j <= 11; j++) begin
            if (j > 1) @(negedge clk);
            else @(negedge clk);
            check($sformatf("lat_busy_c%0d", j), bus8.busy, (j <= 9) ? 1 : 0);
            check($sformatf("lat_done_c%0d", j), bus8.done, (j == 9) ? 1 : 0);
            if (j == 9) begin
                check("lat_sum",  bus8.sum,  8'h7F);
                check("lat_cout", bus8.cout, 0);
            end
        end

        for (int i = 0; i < 7; i++) begin
            go8(tbl[i].a, tbl[i].b, tbl[i].cin);
            wait_done8($sformatf("tbl%0d", i));
            check($sformatf("tbl%0d_sum", i),  bus8.sum,  tbl[i].sum);
            check($sformatf("tbl%0d_cout", i), bus8.cout, tbl[i].cout);
        end

        // start held high; operands change after capture.
        @(posedge clk); #1;
        while (m8_cnt != 0) begin @(posedge clk); #1; end
        bus8.start = 1'b1; bus8.a_in = 8'h35; bus8.b_in = 8'h4A; bus8.cin = 1'b0;
        @(posedge clk); #1;
        bus8.a_in = 8'h10; bus8.b_in = 8'h20;
        wait_done8("hold1");
        t1 = cyc;
        check("hold1_sum",  bus8.sum,  8'h7F);
        check("hold1_cout", bus8.cout, 0);
        @(posedge clk);
        @(posedge clk); #1;
        bus8.start = 1'b0;
        wait_done8("hold2");
        t2 = cyc;
        check("hold_spacing", 32'(t2 - t1), 10);
        check("hold2_sum",  bus8.sum,  8'h30);
        check("hold2_cout", bus8.cout, 0);

        // Reset in the 4th RUN cycle aborts with cleared results.
        go8(8'h35, 8'h4A, 1'b0);
        @(posedge clk); @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", bus8.busy, 0);
        check("abort_sum",  bus8.sum,  0);
        check("abort_cout", bus8.cout, 0);
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus8.done) saw_done = 1'b1;
        end
        check("abort_no_done", 32'(saw_done), 0);

        // rst and start together: the request is dropped.
        @(posedge clk); #1;
        rst = 1'b1; bus8.start = 1'b1; bus8.a_in = 8'h11; bus8.b_in = 8'h22;
        @(posedge clk); #1;
        rst = 1'b0; bus8.start = 1'b0;
        @(negedge clk);
        check("rststart_busy", bus8.busy, 0);

        go8(8'h01, 8'h01, 1'b0);
        wait_done8("fresh");
        check("fresh_sum",  bus8.sum,  8'h02);
        check("fresh_cout", bus8.cout, 0);

        // Exhaustive WIDTH=3 sweep.
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                for (int c = 0; c < 2; c++) begin
                    ref3 = 4'(a) + 4'(b) + 4'(c);
                    go3(3'(a), 3'(b), 1'(c));
                    wait_done3("sweep");
                    check($sformatf("sweep_%0d_%0d_%0d", a, b, c), {bus3.cout, bus3.sum}, ref3);
                end
            end
        end

        repeat (6) @(negedge clk);
        check("sb8_empty", q8.size(), 0);
        check("sb3_empty", q3.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
